// File: rtl/pong_score_keeper_pkg.sv
// rtl/pong_score_keeper_pkg.sv - shared FSM encoding, blank code and 7-segment constants
package pong_score_keeper_pkg;

    localparam logic [0:0] ST_PLAY      = 1'b0;
    localparam logic [0:0] ST_GAME_OVER = 1'b1;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Active-low, bit 0 = segment a through bit 6 = segment g
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD to active-low 7-segment decoder, codes 10-15 blank
module bcd_to_7seg
    import pong_score_keeper_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/pong_score_keeper.sv
// rtl/pong_score_keeper.sv - pong score, high score and lives keeper with multiplexed 4-digit display
module pong_score_keeper
    import pong_score_keeper_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int START_LIVES = 3
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       hit,
    input  logic       point_reset,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic [3:0] high_ones,
    output logic [3:0] high_tens,
    output logic [1:0] lives,
    output logic       game_over,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int              CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(SCAN_DIV - 1);

    logic [0:0]    r_state;
    logic          r_hit_q;
    logic          r_miss_q;
    logic [3:0]    r_score_ones;
    logic [3:0]    r_score_tens;
    logic [3:0]    r_high_ones;
    logic [3:0]    r_high_tens;
    logic [1:0]    r_lives;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    logic          w_hit_rise;
    logic          w_miss_rise;
    logic [7:0]    w_score;
    logic [7:0]    w_high;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg;

    assign w_hit_rise  = hit & ~r_hit_q;
    assign w_miss_rise = point_reset & ~r_miss_q;
    assign w_score     = {r_score_tens, r_score_ones};
    assign w_high      = {r_high_tens, r_high_ones};

    // Game state; a miss always wins over a simultaneous hit
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state      <= ST_PLAY;
            r_hit_q      <= 1'b0;
            r_miss_q     <= 1'b0;
            r_score_ones <= 4'd0;
            r_score_tens <= 4'd0;
            r_high_ones  <= 4'd0;
            r_high_tens  <= 4'd0;
            r_lives      <= 2'(START_LIVES);
        end else begin
            r_hit_q  <= hit;
            r_miss_q <= point_reset;
            if (r_state == ST_PLAY) begin
                if (w_miss_rise) begin
                    if (w_score > w_high) begin
                        r_high_ones <= r_score_ones;
                        r_high_tens <= r_score_tens;
                    end
                    r_score_ones <= 4'd0;
                    r_score_tens <= 4'd0;
                    r_lives      <= r_lives - 2'd1;
                    if (r_lives <= 2'd1) begin
                        r_lives <= 2'd0;
                        r_state <= ST_GAME_OVER;
                    end
                end else if (w_hit_rise && (w_score != 8'h99)) begin
                    if (r_score_ones == 4'd9) begin
                        r_score_ones <= 4'd0;
                        r_score_tens <= r_score_tens + 4'd1;
                    end else begin
                        r_score_ones <= r_score_ones + 4'd1;
                    end
                end
            end else if (w_hit_rise) begin
                r_score_ones <= 4'd0;
                r_score_tens <= 4'd0;
                r_lives      <= 2'(START_LIVES);
                r_state      <= ST_PLAY;
            end
        end
    end

    always_comb begin
        w_digit = BLANK_CODE;
        case (r_idx)
            2'd0:    w_digit = (r_state == ST_GAME_OVER) ? BLANK_CODE : r_score_ones;
            2'd1:    w_digit = (r_state == ST_GAME_OVER) ? BLANK_CODE : r_score_tens;
            2'd2:    w_digit = r_high_ones;
            default: w_digit = r_high_tens;
        endcase
    end

    bcd_to_7seg u_bcd_to_7seg (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    // Display scan; an/seg lag the slot index by one register stage
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
            r_an  <= 4'b1110;
            r_seg <= SEG_0;
        end else begin
            if (r_cnt == CNT_MAX) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_seg;
        end
    end

    assign score_ones = r_score_ones;
    assign score_tens = r_score_tens;
    assign high_ones  = r_high_ones;
    assign high_tens  = r_high_tens;
    assign lives      = r_lives;
    assign game_over  = (r_state == ST_GAME_OVER);
    assign an         = r_an;
    assign seg        = r_seg;

endmodule

// File: doc/pong_score_keeper.md
PONG_SCORE_KEEPER -- requirements
Module: pong_score_keeper

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, giving Clock cycles per display digit slot.
REQ-002 SHALL have parameter START_LIVES, default 3, giving lives loaded at reset and at restart; legal range 1..3.
REQ-003 SHALL have port Clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port hit, input, 1, paddle-hit level from the game stage; may stay high for many cycles, up to end of frame.
REQ-006 SHALL have port point_reset, input, 1, ball-missed level from the game stage; same multi-cycle behaviour as hit.
REQ-007 SHALL have ports score_ones and score_tens, output, 4 each, current score in BCD.
REQ-008 SHALL have ports high_ones and high_tens, output, 4 each, high score in BCD.
REQ-009 SHALL have port lives, output, 2, remaining lives.
REQ-010 SHALL have port game_over, output, 1, high while in state GAME_OVER.
REQ-011 SHALL have port an, output, 4, active-low digit enables.
REQ-012 SHALL have port seg, output, 7, active-low segments; seg[0]=a through seg[6]=g.

Function
REQ-013 SHALL register hit and point_reset into hit_q and miss_q each cycle; hit_rise = hit & ~hit_q; miss_rise = point_reset & ~miss_q.
REQ-014 SHALL implement a two-state FSM: PLAY and GAME_OVER.
REQ-015 In PLAY, on hit_rise, SHALL BCD-increment the score at that edge: ones 9->0 with carry into tens; saturate at 99.
REQ-016 In PLAY, on miss_rise, SHALL load high score := score when {score_tens,score_ones} > {high_tens,high_ones} (8-bit unsigned compare).
REQ-017 In PLAY, on miss_rise, SHALL clear score to 00 and decrement lives.
REQ-018 In PLAY, a miss_rise with lives==1 SHALL set lives 0 and enter GAME_OVER.
REQ-019 If hit_rise and miss_rise occur on the same edge, miss SHALL take priority and the hit SHALL be discarded.
REQ-020 In GAME_OVER, miss_rise SHALL be ignored.
REQ-021 In GAME_OVER, hit_rise SHALL reload lives := START_LIVES, clear score to 00, keep high score, and return to PLAY; that hit SHALL not score.
REQ-022 All score, high-score, lives and game_over outputs SHALL be registered and change only at the edge where the event is detected.
REQ-023 Display scan: a counter runs 0..SCAN_DIV-1; on wrap, digit index advances 0->1->2->3->0.
REQ-024 Digit slot mapping: idx 0 = score_ones, 1 = score_tens, 2 = high_ones, 3 = high_tens; an = ~(1<<idx).
REQ-025 Segment decode: 0-9 use standard patterns (0 = 7'b1000000, 1 = 7'b1111001); codes 10-15 SHALL blank (7'b1111111).
REQ-026 In GAME_OVER, digit slots 0 and 1 SHALL display blank, and slots 2-3 SHALL continue to show the high score.
REQ-027 an and seg SHALL be registered, so a slot change is visible one cycle after the counter wrap.

Reset
REQ-028 While Reset=1 at an edge, the block SHALL load: state PLAY; score 00; high 00; lives START_LIVES; game_over 0.
REQ-029 The same reset SHALL load: hit_q 0; miss_q 0; scan counter 0; idx 0; an 4'b1110; seg 7'b1000000.
REQ-030 Reset SHALL override any simultaneous hit_rise or miss_rise; reset during GAME_OVER SHALL return to PLAY.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the blank code 4'hF, and the segment constants for 0-9 and blank.
REQ-032 Segment decoding SHALL be one combinational sub-module, bcd_to_7seg (4-bit in, 7-bit active-low out), instantiated once on the muxed digit.

Verification
REQ-033 Reset, then hit held high 500 cycles, then low -> score 01 exactly once.
REQ-034 Twelve separated hit pulses -> score_tens=1, score_ones=2; 100 pulses from reset -> score stays 99.
REQ-035 Score 07, high 05, then point_reset pulse -> high 07, score 00, lives 2; then score 03 and a miss -> high stays 07.
REQ-036 hit and point_reset rising on the same edge with score 04 -> score 00, lives decremented, no increment.
REQ-037 Three misses from reset -> lives 0, game_over 1, extra misses ignored; next hit -> lives 3, score 00, game_over 0.
REQ-038 SCAN_DIV=4, high 42 -> an cycles 1110, 1101, 1011, 0111 every 4 cycles, with slot 2 seg = decode(2) and slot 3 seg = decode(4).
